// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   Initiator-side controller between the execute stage and a 4-bank,
//   byte-enabled data memory. Accepts one RV32I load/store at a time, runs a
//   single memory cycle with per-lane enables and lane-replicated write data,
//   then extracts and extends the addressed byte/halfword of the returned word.
//   The core receives the result as a one-cycle response pulse.
//
//   Build option: define LSU_MISALIGN_TRAP_EN to report misaligned half/word
//   requests as errors without touching memory. When it is not defined, those
//   requests are force-aligned to their natural size.
//
// Ports
//   clk, rst_n          clock (rising edge) / async active-low reset
//   req_valid/req_ready request handshake; ready only while idle
//   req_we              1 = store, 0 = load
//   req_funct3          RV32I width/sign code
//   req_addr, req_wdata byte address, right-aligned store data
//   rsp_valid           one-cycle response pulse, no back-pressure
//   rsp_rdata, rsp_err  extended load data (0 for stores/errors), error flag
//   mem_we, mem_rd      memory write / read enable (ACCESS cycle only)
//   mem_ctrl            per-bank enable, bit i = byte lane i
//   mem_addr, mem_di    word-aligned address, lane-replicated write data
//   mem_dout            memory read word, valid the cycle after a read
//   mem_dout_ready      read data valid qualifier
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int RAM_AMOUNT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_we,
  output logic                  mem_rd,
  output logic [RAM_AMOUNT-1:0] mem_ctrl,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_di,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  input  logic                  mem_dout_ready
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_e;

  state_e                  state_q, state_d;
  logic                    we_q, we_d;
  logic [2:0]              f3_q, f3_d;
  logic [DATA_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;

  logic                    accept;
  logic                    f3_bad;
  logic                    misaligned;
  logic                    req_err;
  logic [RAM_AMOUNT-1:0]   mask;
  logic [DATA_WIDTH-1:0]   di_rep;
  logic [7:0]              ld_byte;
  logic [15:0]             ld_half;
  logic [DATA_WIDTH-1:0]   ld_data;

  assign accept = req_valid && (state_q == S_IDLE);

  // Stores only have SB/SH/SW; loads additionally allow LBU/LHU.
  assign f3_bad = req_we ? (req_funct3 > 3'b010)
                         : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  // Lane selection below only looks at the naturally aligned address bits,
  // so misaligned requests are silently force-aligned.
  assign misaligned = 1'b0;
`endif

  assign req_err = f3_bad || misaligned;

  // ---------------------------------------------------------------------------
  // State register and request/response datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned (which would infer a latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (req_valid) state_d = req_err ? S_RESP : S_ACCESS;
      S_ACCESS: state_d = we_q ? S_RESP : S_WAIT;
      S_WAIT:   if (mem_dout_ready) state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Lane mask, write replication and load extraction from the latched request
  // ---------------------------------------------------------------------------
  always_comb begin
    mask   = 4'b1111;
    di_rep = wdata_q;
    unique case (f3_q[1:0])
      2'b00: begin
        mask   = 4'b0001 << addr_q[1:0];
        di_rep = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        mask   = 4'b0011 << {addr_q[1], 1'b0};
        di_rep = {2{wdata_q[15:0]}};
      end
      default: begin
        mask   = 4'b1111;
        di_rep = wdata_q;
      end
    endcase
  end

  always_comb begin
    ld_byte = mem_dout[7:0];
    unique case (addr_q[1:0])
      2'b00: ld_byte = mem_dout[7:0];
      2'b01: ld_byte = mem_dout[15:8];
      2'b10: ld_byte = mem_dout[23:16];
      2'b11: ld_byte = mem_dout[31:24];
      default: ld_byte = mem_dout[7:0];
    endcase
    ld_half = addr_q[1] ? mem_dout[31:16] : mem_dout[15:0];
    unique case (f3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'b0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'b0, ld_half};
      default: ld_data = mem_dout;
    endcase
  end

  // Request capture on accept; response registers load only when RESP is
  // entered, so they hold their value between responses.
  always_comb begin
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (accept) begin
      we_d    = req_we;
      f3_d    = req_funct3;
      addr_d  = req_addr;
      wdata_d = req_wdata;
      if (req_err) begin
        rdata_d = '0;
        err_d   = 1'b1;
      end
    end else if (state_q == S_ACCESS && we_q) begin
      rdata_d = '0;
      err_d   = 1'b0;
    end else if (state_q == S_WAIT && mem_dout_ready) begin
      rdata_d = ld_data;
      err_d   = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ready = (state_q == S_IDLE);
    rsp_valid = (state_q == S_RESP);
    mem_we    = 1'b0;
    mem_rd    = 1'b0;
    mem_ctrl  = '0;
    mem_addr  = '0;
    mem_di    = '0;
    if (state_q == S_ACCESS) begin
      mem_we   = we_q;
      mem_rd   = !we_q;
      mem_ctrl = mask;
      mem_addr = {addr_q[DATA_WIDTH-1:2], 2'b00};
      mem_di   = we_q ? di_rep : '0;
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator-side controller for the 4-bank byte-enabled data memory: accepts RV32I load/store requests from the core and converts them into memory cycles (we, rd, per-bank ctrl, word address, lane-replicated write data).
- Captures the memory read word, extracts and sign- or zero-extends the addressed byte or halfword, and returns a one-cycle response pulse to the core.
- Sits between the execute stage and the data memory.

Parameters:
- DATA_WIDTH, 32, data/address width; only 32 is supported.
- RAM_AMOUNT, 4, number of byte banks (byte-enable width); only 4 is supported.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  core request strobe
- req_ready  output  1  unit idle, request accepted when req_valid && req_ready
- req_we  input  1  1=store, 0=load
- req_funct3  input  3  RV32I width/sign code (LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101)
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned
- rsp_valid  output  1  one-cycle response pulse
- rsp_rdata  output  32  extended load data; 0 for stores and errors
- rsp_err  output  1  invalid funct3 or trapped misalignment
- mem_we  output  1  memory write enable
- mem_rd  output  1  memory read enable
- mem_ctrl  output  4  per-bank enable, bit i = bank i (byte lane i)
- mem_addr  output  32  word-aligned address {addr[31:2],2'b00}
- mem_di  output  32  lane-replicated write data
- mem_dout  input  32  memory read word, valid the cycle after an enabled read
- mem_dout_ready  input  1  read data valid qualifier

Behaviour:
- One clock (clk); reset is asynchronous, active-low (rst_n).
- Reset state is IDLE. Reset values: req_ready=1, mem_we=0, mem_rd=0, mem_ctrl=0, mem_addr=0, mem_di=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Reset asserted mid-operation forces these values immediately and abandons the request. Write cycles completed before reset stand.
- Request is latched on acceptance. Request inputs are ignored outside IDLE.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - req_ready=1. All mem_* enables are 0.
  - On accept with an error condition, go to RESP with err=1 and no memory access.
  - On any other store or load accept, go to ACCESS.
- ACCESS (one cycle):
  - mem_ctrl=mask, mem_addr=word address.
  - Store: mem_we=1, mem_di=replicated data, then go to RESP.
  - Load: mem_rd=1, mem_we=0, then go to WAIT.
- WAIT:
  - mem_ctrl=0 so banks hold their output.
  - Stay while mem_dout_ready=0.
  - When mem_dout_ready=1, capture the extracted value and go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, then go to IDLE. There is no back-pressure; the core must take the pulse.
- Latency from the accept cycle to rsp_valid:
  - store: 2 cycles
  - load: 3 cycles, plus each cycle mem_dout_ready is low
  - error: 1 cycle
- Mask: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<{addr[1],1'b0}; word = 4'b1111.
- mem_di: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
- Load extract: byte = mem_dout[8*addr[1:0] +: 8]; half = mem_dout[16*addr[1] +: 16].
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes the word unchanged.
- Invalid funct3 sets err=1:
  - loads: 011, 110, 111
  - stores: any value other than 000/001/010
- Misaligned conditions: half with addr[0]=1; word with addr[1:0]!=0. See Optional Feature.
- rsp_rdata and rsp_err are registered. They are held until the next RESP and cleared only by reset.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: a misaligned request gives rsp_err=1 and rsp_rdata=0 after 1 cycle. No memory enable is ever asserted for it.
- Undefined: misaligned requests proceed with the address force-aligned to natural size, with rsp_err=0.
  - half uses addr[1] only;
  - word ignores addr[1:0].

Test Plan:
- SW addr 0x10 data 0xDEADBEEF -> ACCESS cycle: mem_we=1, mem_ctrl=1111, mem_addr=0x10, mem_di=0xDEADBEEF; rsp_valid 2 cycles after accept, err=0. Then LW 0x10 -> rsp_rdata=0xDEADBEEF 3 cycles after accept.
- SB addr 0x13 data 0x000000A5 -> mem_ctrl=1000, mem_di=0xA5A5A5A5. Then LB 0x13 -> 0xFFFFFFA5; LBU 0x13 -> 0x000000A5. Bytes 0x10-0x12 are unchanged (LW 0x10 -> 0xA5ADBEEF).
- SH addr 0x12 data 0x8001 -> mem_ctrl=1100, mem_di=0x80018001. Then LH 0x12 -> 0xFFFF8001; LHU 0x12 -> 0x00008001.
- LW 0x10 with mem_dout_ready held 0 for 3 cycles in WAIT -> FSM stays in WAIT with mem_ctrl=0 and req_ready=0; rsp_valid comes 1 cycle after ready rises, data correct.
- LW 0x11:
  - macro defined -> rsp_err=1, rdata=0, rsp_valid 1 cycle after accept, mem_ctrl never nonzero;
  - undefined -> word at 0x10 returned, err=0.
- Load with funct3=011 -> rsp_err=1, no memory access. Separately, rst_n low during WAIT -> outputs reset immediately, req_ready=1, no rsp_valid.
